// File: rtl/dmem_pkg.sv
// Shared definitions for the pipelined data memory.
//   dmem_state_e : the INIT sweep and RUN states
//   byte_par     : even-parity bit for one byte
//   RD_LAT_MIN/MAX : legal read-latency range
package dmem_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } dmem_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  // The stored bit makes byte plus parity have an even number of ones.
  function automatic logic byte_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/dmem_rd_pipe.sv
// Read-response delay line that sits after the registered RAM read.
// Adds STAGES extra cycles; STAGES = 0 is a straight passthrough.
//   clk, rst              : clock, synchronous active-high clear of all stages
//   in_valid/data/err     : response from the RAM read register
//   out_valid/data/err    : delayed response
module dmem_rd_pipe #(
  parameter int DATA_W = 16,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_err,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  generate
    if (STAGES == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign out_valid = in_valid;
      assign out_data  = in_data;
      assign out_err   = in_err;
    end else begin : g_pipe
      logic [STAGES-1:0]             vld_q, vld_d;
      logic [STAGES-1:0]             err_q, err_d;
      logic [STAGES-1:0][DATA_W-1:0] dat_q, dat_d;

      always_comb begin
        vld_d    = vld_q;
        err_d    = err_q;
        dat_d    = dat_q;
        vld_d[0] = in_valid;
        err_d[0] = in_err;
        dat_d[0] = in_data;
        for (int i = 1; i < STAGES; i++) begin
          vld_d[i] = vld_q[i-1];
          err_d[i] = err_q[i-1];
          dat_d[i] = dat_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= '0;
          err_q <= '0;
          dat_q <= '0;
        end else begin
          vld_q <= vld_d;
          err_q <= err_d;
          dat_q <= dat_d;
        end
      end

      assign out_valid = vld_q[STAGES-1];
      assign out_data  = dat_q[STAGES-1];
      assign out_err   = err_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/dmem_pipe.sv
// Pipelined data memory with valid/ready requests, byte enables, a
// zero-fill sweep after reset and RD_LAT-cycle registered loads.
// Optional feature macro: DMEM_PARITY_EN (per-byte even parity, checked
// on loads and reported through rsp_err).
//   clk, rst                   : clock, synchronous active-high reset
//   req_valid/ready            : request handshake (ready only in RUN)
//   req_wr, req_addr           : 1 = store / 0 = load, word address
//   req_wdata, req_be          : store data and byte enables
//   rsp_valid, rsp_rdata, rsp_err : load response (data/err zero when idle)
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT   = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
`ifdef DMEM_PARITY_EN
  logic [NB-1:0]     mem_par [DEPTH];
`endif

  // ---------------- INIT / RUN control ----------------
  dmem_state_e      state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             init_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready = (state_q == ST_RUN);

  // ---------------- request decode ----------------
  logic             accept, in_range, st_we;
  logic [IDX_W-1:0] idx;

  assign accept   = req_valid && req_ready;
  assign in_range = {1'b0, req_addr} < DEPTH_A;
  assign idx      = req_addr[IDX_W-1:0];
  // Out-of-range stores are dropped; be = 0 naturally writes nothing.
  assign st_we    = accept && req_wr && in_range;

  // RAM: no reset on contents, the INIT sweep zero-fills it instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (init_we) begin
        mem[cnt_q] <= '0;
`ifdef DMEM_PARITY_EN
        mem_par[cnt_q] <= '0;
`endif
      end else if (st_we) begin
        for (int i = 0; i < NB; i++) begin
          if (req_be[i]) begin
            mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
`ifdef DMEM_PARITY_EN
            mem_par[idx][i] <= byte_par(req_wdata[8*i +: 8]);
`endif
          end
        end
      end
    end
  end

  // ---------------- registered read ----------------
  logic              rd_vld_q, rd_vld_d;
  logic              rd_err_q, rd_err_d;
  logic [DATA_W-1:0] rd_dat_q, rd_dat_d;

  always_comb begin
    rd_vld_d = accept && !req_wr;
    rd_dat_d = '0;
    rd_err_d = 1'b0;
    if (rd_vld_d) begin
      if (in_range) begin
        rd_dat_d = mem[idx];
`ifdef DMEM_PARITY_EN
        for (int i = 0; i < NB; i++) begin
          if (byte_par(mem[idx][8*i +: 8]) != mem_par[idx][i]) rd_err_d = 1'b1;
        end
`endif
      end else begin
        rd_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q <= 1'b0;
      rd_err_q <= 1'b0;
      rd_dat_q <= '0;
    end else begin
      rd_vld_q <= rd_vld_d;
      rd_err_q <= rd_err_d;
      rd_dat_q <= rd_dat_d;
    end
  end

  logic              p_vld, p_err;
  logic [DATA_W-1:0] p_dat;

  dmem_rd_pipe #(
    .DATA_W (DATA_W),
    .STAGES (LAT - 1)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_vld_q),
    .in_data   (rd_dat_q),
    .in_err    (rd_err_q),
    .out_valid (p_vld),
    .out_data  (p_dat),
    .out_err   (p_err)
  );

  // Data and error are forced to zero outside a valid response.
  assign rsp_valid = p_vld;
  assign rsp_rdata = p_vld ? p_dat : '0;
  assign rsp_err   = p_vld & p_err;

endmodule

// File: tb/tb_dmem_pipe.sv
module tb_dmem_pipe;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 16;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_be;
  logic              rsp_valid, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_pipe #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are then changed 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles with req_ready low (bounded), watching for stray responses.
  task automatic wait_init(input string tag);
    int n = 0;
    logic stray = 1'b0;
    while (!req_ready && n < 100) begin
      if (rsp_valid) stray = 1'b1;
      tick();
      n++;
    end
    chk({tag, "_len"}, n, DEPTH);
    chk({tag, "_no_rsp"}, {31'd0, stray}, 0);
  endtask

  task automatic store(input logic [ADDR_W-1:0] a, input logic [15:0] d, input logic [1:0] be);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d; req_be = be;
    tick();
    req_valid = 1'b0; req_wr = 1'b0;
  endtask

  // Load, then check the response appears exactly RD_LAT (=2) cycles later.
  task automatic load_chk(input string tag, input logic [ADDR_W-1:0] a,
                          input logic [15:0] d, input logic e);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = a;
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_early"}, {31'd0, rsp_valid}, 0);
    tick();
    @(negedge clk);
    chk({tag, "_vld"}, {31'd0, rsp_valid}, 1);
    chk({tag, "_data"}, {16'd0, rsp_rdata}, {16'd0, d});
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e});
    tick();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 0);
    chk("rst_vld", {31'd0, rsp_valid}, 0);
    chk("rst_data", {16'd0, rsp_rdata}, 0);
    chk("rst_err", {31'd0, rsp_err}, 0);
    tick();
    rst = 1'b0;
    wait_init("init");

    load_chk("ld5_zero", 16'd5, 16'h0000, 1'b0);

    store(16'd3, 16'hBEEF, 2'b11);
    load_chk("raw3", 16'd3, 16'hBEEF, 1'b0);
    store(16'd3, 16'h1234, 2'b01);
    load_chk("be_lo", 16'd3, 16'hBE34, 1'b0);
    store(16'd3, 16'h5678, 2'b00);
    load_chk("be_none", 16'd3, 16'hBE34, 1'b0);
    store(16'd3, 16'hAA00, 2'b10);
    load_chk("be_hi", 16'd3, 16'hAA34, 1'b0);

    // Back-to-back loads of 0,1,2.
    store(16'd0, 16'h1111, 2'b11);
    store(16'd1, 16'h2222, 2'b11);
    store(16'd2, 16'h3333, 2'b11);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'd0;
    tick();
    req_addr = 16'd1;
    tick();
    req_addr = 16'd2;
    @(negedge clk);
    chk("b2b0_vld", {31'd0, rsp_valid}, 1);
    chk("b2b0_data", {16'd0, rsp_rdata}, 32'h1111);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b1_vld", {31'd0, rsp_valid}, 1);
    chk("b2b1_data", {16'd0, rsp_rdata}, 32'h2222);
    tick();
    @(negedge clk);
    chk("b2b2_vld", {31'd0, rsp_valid}, 1);
    chk("b2b2_data", {16'd0, rsp_rdata}, 32'h3333);
    tick();
    @(negedge clk);
    chk("b2b_end_vld", {31'd0, rsp_valid}, 0);
    chk("idle_data", {16'd0, rsp_rdata}, 0);

    // Out-of-range: load flags error; store must not alias onto word 4 or any other.
    load_chk("oor_ld", 16'd20, 16'h0000, 1'b1);
    store(16'd20, 16'hFFFF, 2'b11);
    load_chk("oor_st4", 16'd4, 16'h0000, 1'b0);
    load_chk("oor_st3", 16'd3, 16'hAA34, 1'b0);
    load_chk("top_word", 16'd15, 16'h0000, 1'b0);

`ifdef DMEM_PARITY_EN
    dut.mem[7] = dut.mem[7] ^ 16'h0001;
    load_chk("par_err", 16'd7, 16'h0001, 1'b1);
`endif

    // Reset with loads in flight: nothing may come out, INIT reruns.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'd3;
    tick();
    req_addr = 16'd1; rst = 1'b1;
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_vld", {31'd0, rsp_valid}, 0);
    chk("mid_rst_ready", {31'd0, req_ready}, 0);
    tick();
    rst = 1'b0;
    wait_init("reinit");
    load_chk("lost3", 16'd3, 16'h0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_pipe.md
# dmem_pipe

Parametrised, pipelined data memory for the RISC-16 core, replacing the flat combinational-read data RAM. It adds a valid/ready request interface, per-byte write enables, and a configurable registered read latency. A hardware zero-initialisation sweep runs after reset. Bounds checking on every access is always present, with optional per-byte parity. The block sits between the execute/memory stage and the load-writeback path.

## Interface
- `DATA_W`, default 16: word width; must be a multiple of 8.
- `DEPTH`, default 1024: number of words; need not be a power of two.
- `ADDR_W`, default 16: request address width; must satisfy `2^ADDR_W >= DEPTH`.
- `RD_LAT`, default 1: read latency in cycles; legal range 1–3.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block accepts a request this cycle.
- `req_wr` in 1: 1 = store, 0 = load.
- `req_addr` in `ADDR_W`: word address.
- `req_wdata` in `DATA_W`: store data.
- `req_be` in `DATA_W/8`: byte enables for stores; bit i covers byte i. Ignored for loads.
- `rsp_valid` out 1: load data valid; one-cycle pulse per accepted load.
- `rsp_rdata` out `DATA_W`: load data. Reads 0 whenever `rsp_valid` = 0.
- `rsp_err` out 1: load error flag. Qualified by `rsp_valid`; 0 otherwise.

## Operation
- State machine has two states: INIT and RUN.
- `rst` = 1 forces INIT and sets the init counter to 0. It also clears every read-pipeline stage.
- In INIT:
  - One word is written per cycle with all bytes zero (parity bits zero as well), at the address held in the counter.
  - The counter increments each cycle. After writing word `DEPTH-1`, the state moves to RUN.
  - `req_ready` = 0 throughout INIT.
- In RUN, `req_ready` = 1.
- A request is accepted when `req_valid && req_ready`.
- Accepted store:
  - Each byte i with `req_be[i]` = 1 is written on the accepting edge. Other bytes keep their value.
  - Stores produce no response.
  - A store with `req_addr >= DEPTH` is dropped silently.
  - A store with `req_be` = 0 changes nothing.
- Accepted load:
  - The block issues a response `RD_LAT` cycles later.
  - If `req_addr >= DEPTH`, the response has `rsp_rdata` = 0 and `rsp_err` = 1.
- Ordering:
  - A load accepted in the cycle after a store to the same address returns the new data.
  - Only one request can be accepted per cycle, so there is no same-cycle read/write conflict.
- Back-to-back loads:
  - One load may be accepted every cycle.
  - Responses come out in order, one per cycle.
- Reset mid-operation: in-flight loads are discarded with no `rsp_valid`, and the block re-runs INIT, so memory contents are lost.
- Reset values: `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.

## Timing
- INIT length:
  - `req_ready` rises after exactly `DEPTH` rising edges with `rst` = 0 following reset release.
  - It is first observable high in cycle `DEPTH`, counting the first cycle with `rst` low as cycle 0.
- Loads: a load accepted at edge N gives `rsp_valid` = 1 in the cycle after edge `N+RD_LAT-1`. With `RD_LAT` = 1, data is valid in the cycle after acceptance.
- Stores take effect at the accepting edge.
- There is no response back-pressure; the consumer must always take `rsp_*`.
- `req_ready` depends only on state, never combinationally on `req_valid`.

## Configuration
- `DMEM_PARITY_EN` defined:
  - One even-parity bit per byte is stored alongside the data and written with that byte.
  - On a load, parity is recomputed. Any byte mismatch sets `rsp_err` = 1, with `rsp_rdata` carrying the raw stored data.
- `DMEM_PARITY_EN` undefined:
  - No parity storage and no parity logic.
  - `rsp_err` flags out-of-range loads only.

## Structure
- Shared package `dmem_pkg` holds:
  - the state enum {INIT, RUN};
  - the byte-parity function;
  - the `RD_LAT` legal-range constants.
- One sub-module, `dmem_rd_pipe`: a valid/data/err shift register of depth `RD_LAT - 1` placed after the registered RAM read. It is cleared by `rst`.
- The RAM array plus the INIT counter stay in the top module.

## Test plan
All scenarios use `DEPTH`=16, `DATA_W`=16, `RD_LAT`=2.
- Reset then idle:
  - `req_ready` = 0 for cycles 0–15 and 1 in cycle 16.
  - A load of address 5 returns 0x0000 with `rsp_err` = 0, two cycles after acceptance.
- Store 0xBEEF to address 3 with `be`=2'b11, load address 3 in the next cycle → 0xBEEF.
- Store 0x1234 to address 3 with `be`=2'b01 → load returns 0xBE34.
- Load addresses 0, 1, 2 back-to-back → three consecutive `rsp_valid` cycles, in order.
- Load address 20 → `rsp_rdata` = 0, `rsp_err` = 1. Store to address 20 → no memory word changes.
- Assert `rst` with two loads in flight → no `rsp_valid` appears, and INIT restarts (16 cycles of `req_ready` = 0).
- With `DMEM_PARITY_EN`: hierarchically flip one data bit of word 7, then load address 7 → `rsp_err` = 1.
